// File: rtl/vdf_pkg.sv
// Shared types and size helpers for the VDF squaring-loop controller.
// Used by vdf_sq_loop_ctrl and its optional watchdog (SQ_LOOP_TIMEOUT_EN).
package vdf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sq_state_t;

    // One extra word beyond the modulus holds the redundant-form carry.
    function automatic int unsigned calc_i_word(input int unsigned num_words);
        return num_words + 1;
    endfunction

    function automatic int unsigned calc_coef_bits(input int unsigned word_bits,
                                                   input int unsigned redun_bits);
        return word_bits + redun_bits;
    endfunction

endpackage

// File: rtl/sq_loop_watchdog.sv
// Cycle watchdog for the squarer wait phase; counts while i_run is high.
// Only instantiated when SQ_LOOP_TIMEOUT_EN is defined.
module sq_loop_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_expire_c
);

    localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_BITS-1:0] r_cnt;

    // Fires on the last allowed wait cycle so the controller leaves WAIT
    // exactly TIMEOUT_CYCLES cycles after entering it.
    assign o_expire_c = i_run && (r_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (!o_expire_c) begin
            r_cnt <= r_cnt + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/vdf_sq_loop_ctrl.sv
// Sequencer that feeds a value through an external squarer T times and returns it.
// Define SQ_LOOP_TIMEOUT_EN to add a wait-phase watchdog that reports o_err.
module vdf_sq_loop_ctrl
    import vdf_pkg::*;
#(
    parameter int unsigned WORD_BITS       = 16,
    parameter int unsigned NUM_WORDS       = 4,
    parameter int unsigned REDUN_WORD_BITS = 1,
    parameter int unsigned ITER_BITS       = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    localparam int unsigned I_WORD    = calc_i_word(NUM_WORDS),
    localparam int unsigned COEF_BITS = calc_coef_bits(WORD_BITS, REDUN_WORD_BITS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,

    input  logic                             i_val,
    input  logic [I_WORD-1:0][COEF_BITS-1:0] i_dat,
    input  logic [ITER_BITS-1:0]             i_iter,
    output logic                             o_rdy,
    input  logic                             i_abort,

    output logic                             o_mul_val,
    output logic [I_WORD-1:0][COEF_BITS-1:0] o_mul_dat,
    input  logic                             i_mul_val,
    input  logic [I_WORD-1:0][COEF_BITS-1:0] i_mul_dat,

    output logic                             o_val,
    output logic [I_WORD-1:0][COEF_BITS-1:0] o_dat,
    output logic                             o_err,
    input  logic                             i_rdy
);

    typedef logic [I_WORD-1:0][COEF_BITS-1:0] word_vec_t;

    sq_state_t            r_state;
    sq_state_t            w_state_nxt;
    word_vec_t            r_work;
    word_vec_t            w_work_nxt;
    logic [ITER_BITS-1:0] r_rem;
    logic [ITER_BITS-1:0] w_rem_nxt;
    logic [ITER_BITS-1:0] w_rem_dec;
    logic                 r_outstanding;
    logic                 w_out_nxt;
    logic                 w_err_set;
    logic                 w_timeout;

    logic                 r_rdy;
    logic                 r_mul_val;
    word_vec_t            r_mul_dat;
    logic                 r_val;
    word_vec_t            r_dat;

    assign o_rdy     = r_rdy;
    assign o_mul_val = r_mul_val;
    assign o_mul_dat = r_mul_dat;
    assign o_val     = r_val;
    assign o_dat     = r_dat;

    // Next-state, working value and iteration count.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_rem_nxt   = r_rem;
        w_err_set   = 1'b0;
        w_rem_dec   = r_rem - ITER_BITS'(1);

        case (r_state)
            ST_IDLE: begin
                if (i_val && r_rdy) begin
                    w_work_nxt  = i_dat;
                    w_rem_nxt   = i_iter;
                    w_state_nxt = (i_iter == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_mul_val) begin
                    w_work_nxt  = i_mul_dat;
                    w_rem_nxt   = w_rem_dec;
                    w_state_nxt = (w_rem_dec == '0) ? ST_DONE : ST_ISSUE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_err_set   = 1'b1;
                end
            end
            ST_DONE: begin
                if (i_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a start or a result in the same cycle.
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_work_nxt  = r_work;
            w_rem_nxt   = r_rem;
            w_err_set   = 1'b0;
        end

        // A request issued this cycle is in flight even if an old response lands now.
        w_out_nxt = r_outstanding;
        if (i_mul_val) begin
            w_out_nxt = 1'b0;
        end
        if (r_mul_val) begin
            w_out_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_work        <= '0;
            r_rem         <= '0;
            r_outstanding <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_work        <= w_work_nxt;
            r_rem         <= w_rem_nxt;
            r_outstanding <= w_out_nxt;
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdy     <= 1'b1;
            r_mul_val <= 1'b0;
            r_mul_dat <= '0;
            r_val     <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_rdy     <= (w_state_nxt == ST_IDLE) && !w_out_nxt;
            r_mul_val <= (w_state_nxt == ST_ISSUE);
            r_val     <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_ISSUE) begin
                r_mul_dat <= w_work_nxt;
            end
            if (w_state_nxt == ST_DONE) begin
                r_dat <= w_work_nxt;
            end
        end
    end

`ifdef SQ_LOOP_TIMEOUT_EN
    logic r_err;

    sq_loop_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_run      (r_state == ST_WAIT),
        .o_expire_c (w_timeout)
    );

    // Error flag lives exactly as long as the result it qualifies.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_state_nxt == ST_DONE) &&
                     (w_err_set || ((r_state == ST_DONE) && r_err));
        end
    end

    assign o_err = r_err;
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
    assign w_unused  = ^{w_err_set, 32'(TIMEOUT_CYCLES)};
`endif

endmodule
